// File: rtl/mem_pkg.sv
// Shared encodings for the data-memory port: access sizes, read/write flag,
// responder states, the latched request record and the store-lane helpers.
package mem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    localparam logic MEM_READ  = 1'b1;
    localparam logic MEM_WRITE = 1'b0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        ACCESS  = 2'd2,
        RESPOND = 2'd3
    } rsp_state_e;

    typedef struct packed {
        logic [31:0] address;
        logic        read_write;
        logic [1:0]  access_size;
        logic        is_unsigned;
        logic [31:0] wdata;
    } mem_req_t;

    // Byte-enable mirror of the load lane selection in dmem_load_align.
    function automatic logic [3:0] store_lane_mask(input logic [1:0] lane, input logic [1:0] size);
        case (size)
            SIZE_BYTE: store_lane_mask = 4'b0001 << lane;
            SIZE_HALF: store_lane_mask = lane[1] ? 4'b1100 : 4'b0011;
            SIZE_WORD: store_lane_mask = 4'b1111;
            default:   store_lane_mask = 4'b0000;
        endcase
    endfunction

    // Replicating right-aligned store data puts it under every candidate lane;
    // the mask then picks the addressed one.
    function automatic logic [31:0] store_lane_data(input logic [31:0] wdata, input logic [1:0] size);
        case (size)
            SIZE_BYTE: store_lane_data = {4{wdata[7:0]}};
            SIZE_HALF: store_lane_data = {2{wdata[15:0]}};
            default:   store_lane_data = wdata;
        endcase
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store request and response handshake between the core's data initiator
// and the memory responder.
interface dmem_responder_if;

    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_address;
    logic        req_read_write;
    logic [1:0]  req_access_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic        busy;

    modport master (
        output req_valid, req_address, req_read_write, req_access_size, req_unsigned, req_wdata,
        output rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error, busy
    );

    modport slave (
        input  req_valid, req_address, req_read_write, req_access_size, req_unsigned, req_wdata,
        input  rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_error, busy
    );

endinterface

// File: rtl/dmem_load_align.sv
// Little-endian lane extraction for loads: picks the byte/half addressed by the
// low address bits and sign- or zero-extends it; words pass through.
module dmem_load_align
    import mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = 8'(word >> {lane, 3'b000});
    assign half_sel = 16'(word >> {lane[1], 4'b0000});

    always_comb begin
        data = word;
        case (size)
            SIZE_BYTE: data = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
            SIZE_HALF: data = {{16{~is_unsigned & half_sel[15]}}, half_sel};
            default:   data = word;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory target: one request in flight, programmable wait
// states, then a single ACCESS cycle that checks, reads or writes storage.
module dmem_responder
    import mem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0100_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_CYCLES = 2
) (
    input logic             clock,
    input logic             reset,
    dmem_responder_if.slave bus
);

    localparam int          AW   = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN = 32'(4 * DEPTH_WORDS);

    rsp_state_e    state_q, state_d;
    logic [3:0]    wait_cnt_q, wait_cnt_d;
    mem_req_t      req_q, req_d;
    logic          busy_q, busy_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic          rsp_error_q, rsp_error_d;
    logic [31:0]   rsp_rdata_q, rsp_rdata_d;

    logic [31:0]   mem [DEPTH_WORDS];
    logic [31:0]   offset;
    logic [AW-1:0] word_idx;
    logic          acc_error;
    logic          wr_en;
    logic [3:0]    wr_mask;
    logic [31:0]   wr_data;
    logic [31:0]   load_data;

    // Offset wraps, so addresses below BASE_ADDR land far out of range.
    assign offset   = req_q.address - BASE_ADDR;
    assign word_idx = offset[AW+1:2];

    always_comb begin
        acc_error = 1'b0;
        if (offset >= SPAN)                                               acc_error = 1'b1;
        if (req_q.access_size == 2'd3)                                    acc_error = 1'b1;
        if (req_q.access_size == SIZE_HALF && req_q.address[0])           acc_error = 1'b1;
        if (req_q.access_size == SIZE_WORD && req_q.address[1:0] != 2'd0) acc_error = 1'b1;
    end

    dmem_load_align u_align (
        .word        (mem[word_idx]),
        .lane        (req_q.address[1:0]),
        .size        (req_q.access_size),
        .is_unsigned (req_q.is_unsigned),
        .data        (load_data)
    );

    // A write whose ACCESS edge meets reset is dropped along with the request.
    assign wr_en   = (state_q == ACCESS) && !acc_error && (req_q.read_write == MEM_WRITE) && !reset;
    assign wr_mask = store_lane_mask(req_q.address[1:0], req_q.access_size);
    assign wr_data = store_lane_data(req_q.wdata, req_q.access_size);

    always_ff @(posedge clock) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_mask[b]) mem[word_idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        req_d       = req_q;
        busy_d      = busy_q;
        rsp_valid_d = rsp_valid_q;
        rsp_error_d = rsp_error_q;
        rsp_rdata_d = rsp_rdata_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    req_d = '{address:     bus.req_address,
                              read_write:  bus.req_read_write,
                              access_size: bus.req_access_size,
                              is_unsigned: bus.req_unsigned,
                              wdata:       bus.req_wdata};
                    busy_d = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_d = ACCESS;
                    end else begin
                        state_d    = WAIT;
                        wait_cnt_d = 4'(WAIT_CYCLES - 1);
                    end
                end
            end
            WAIT: begin
                if (wait_cnt_q == 4'd0) state_d = ACCESS;
                else                    wait_cnt_d = wait_cnt_q - 4'd1;
            end
            ACCESS: begin
                rsp_valid_d = 1'b1;
                rsp_error_d = acc_error;
                rsp_rdata_d = (acc_error || req_q.read_write == MEM_WRITE) ? 32'd0 : load_data;
                state_d     = RESPOND;
            end
            RESPOND: begin
                if (bus.rsp_ready) begin
                    state_d     = IDLE;
                    busy_d      = 1'b0;
                    rsp_valid_d = 1'b0;
                    rsp_error_d = 1'b0;
                    rsp_rdata_d = 32'd0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            wait_cnt_q  <= 4'd0;
            req_q       <= '0;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_error_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            req_q       <= req_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_error_q <= rsp_error_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Ready is held low through reset and rises the first cycle after it.
    assign bus.req_ready = (state_q == IDLE) && !reset;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_error = rsp_error_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed vector table, reset/backpressure sequences,
// and random traffic against a byte-level memory model.
module tb_dmem_responder;
    import mem_pkg::*;

    localparam logic [31:0] BASE  = 32'h0100_0000;
    localparam int          DEPTH = 1024;
    localparam int          WCYC  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    dmem_responder_if bus ();

    dmem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WCYC)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    typedef struct {
        logic        rw;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_er;
    } vec_t;

    vec_t       vt [17];
    logic [7:0] mb [64];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic send(input logic rw, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd);
        int n = 0;
        @(negedge clk);
        bus.req_valid       = 1'b1;
        bus.req_read_write  = rw;
        bus.req_access_size = sz;
        bus.req_unsigned    = uns;
        bus.req_address     = a;
        bus.req_wdata       = wd;
        while (!bus.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("accept_timeout", 32'(n), 32'd0);
        @(posedge clk);
        #1;
        bus.req_valid   = 1'b0;
        bus.req_address = $urandom;
        bus.req_wdata   = $urandom;
    endtask

    task automatic finish_req(input string nm, input logic [31:0] exp_rd, input logic exp_er, input int hold);
        int lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.rsp_valid && lat < 40);
        chk({nm, ".latency"}, 32'(lat), 32'(2 + WCYC));
        chk({nm, ".rdata"}, bus.rsp_rdata, exp_rd);
        chk({nm, ".error"}, 32'(bus.rsp_error), 32'(exp_er));
        repeat (hold) begin
            @(negedge clk);
            chk({nm, ".hold_valid"}, 32'(bus.rsp_valid), 32'd1);
            chk({nm, ".hold_rdata"}, bus.rsp_rdata, exp_rd);
            chk({nm, ".hold_error"}, 32'(bus.rsp_error), 32'(exp_er));
            chk({nm, ".hold_req_ready"}, 32'(bus.req_ready), 32'd0);
            chk({nm, ".hold_busy"}, 32'(bus.busy), 32'd1);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        chk({nm, ".retire_req_ready"}, 32'(bus.req_ready), 32'd1);
        chk({nm, ".retire_valid"}, 32'(bus.rsp_valid), 32'd0);
        chk({nm, ".retire_busy"}, 32'(bus.busy), 32'd0);
    endtask

    function automatic logic ref_err(input logic [31:0] a, input logic [1:0] sz);
        logic [31:0] off = a - BASE;
        return (off >= 32'(4 * DEPTH)) || (sz == 2'd3) ||
               (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && (a % 4) != 0);
    endfunction

    // Byte-addressed model over the first 64 bytes of storage.
    task automatic ref_access(input logic rw, input logic [1:0] sz, input logic uns,
                              input logic [31:0] a, input logic [31:0] wd,
                              output logic [31:0] rd, output logic er);
        int          off, nb;
        logic [31:0] v;
        er = ref_err(a, sz);
        rd = 32'd0;
        if (er) return;
        off = int'(a - BASE);
        nb  = 1 << sz;
        if (rw == MEM_READ) begin
            v = 32'd0;
            for (int i = 0; i < nb; i++) v = v | (32'(mb[off + i]) << (8 * i));
            if (!uns && nb < 4 && v[8 * nb - 1]) v = v | ~((32'd1 << (8 * nb)) - 32'd1);
            rd = v;
        end else begin
            for (int i = 0; i < nb; i++) mb[off + i] = wd[8 * i +: 8];
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, a, wd;
        logic        er, rw, uns;
        logic [1:0]  sz;

        vt[0]  = '{MEM_WRITE, SIZE_WORD, 1'b0, BASE + 8,  32'hDEADBEEF, 32'h0,        1'b0};
        vt[1]  = '{MEM_READ,  SIZE_WORD, 1'b0, BASE + 8,  32'h0,        32'hDEADBEEF, 1'b0};
        vt[2]  = '{MEM_READ,  SIZE_BYTE, 1'b0, BASE + 9,  32'h0,        32'hFFFFFFBE, 1'b0};
        vt[3]  = '{MEM_READ,  SIZE_BYTE, 1'b1, BASE + 9,  32'h0,        32'h000000BE, 1'b0};
        vt[4]  = '{MEM_READ,  SIZE_HALF, 1'b0, BASE + 10, 32'h0,        32'hFFFFDEAD, 1'b0};
        vt[5]  = '{MEM_READ,  SIZE_HALF, 1'b1, BASE + 10, 32'h0,        32'h0000DEAD, 1'b0};
        vt[6]  = '{MEM_WRITE, SIZE_BYTE, 1'b0, BASE + 11, 32'hFFFFFF12, 32'h0,        1'b0};
        vt[7]  = '{MEM_READ,  SIZE_WORD, 1'b0, BASE + 8,  32'h0,        32'h12ADBEEF, 1'b0};
        vt[8]  = '{MEM_WRITE, SIZE_WORD, 1'b0, BASE + 0,  32'h11223344, 32'h0,        1'b0};
        vt[9]  = '{MEM_READ,  SIZE_WORD, 1'b0, BASE + 2,  32'h0,        32'h0,        1'b1};
        vt[10] = '{MEM_WRITE, SIZE_HALF, 1'b0, BASE + 1,  32'h0000AAAA, 32'h0,        1'b1};
        vt[11] = '{MEM_READ,  SIZE_WORD, 1'b0, BASE + 0,  32'h0,        32'h11223344, 1'b0};
        vt[12] = '{MEM_READ,  SIZE_WORD, 1'b0, BASE + 4 * DEPTH, 32'h0, 32'h0,        1'b1};
        vt[13] = '{MEM_READ,  2'd3,      1'b0, BASE + 0,  32'h0,        32'h0,        1'b1};
        vt[14] = '{MEM_READ,  SIZE_WORD, 1'b0, BASE - 4,  32'h0,        32'h0,        1'b1};
        vt[15] = '{MEM_WRITE, SIZE_WORD, 1'b0, BASE + 4 * DEPTH - 4, 32'hA5B6C7D8, 32'h0, 1'b0};
        vt[16] = '{MEM_READ,  SIZE_BYTE, 1'b0, BASE + 4 * DEPTH - 1, 32'h0, 32'hFFFFFFA5, 1'b0};

        bus.req_valid       = 1'b0;
        bus.req_read_write  = MEM_READ;
        bus.req_access_size = SIZE_WORD;
        bus.req_unsigned    = 1'b0;
        bus.req_address     = 32'd0;
        bus.req_wdata       = 32'd0;
        bus.rsp_ready       = 1'b0;

        repeat (3) @(negedge clk);
        chk("reset.req_ready", 32'(bus.req_ready), 32'd0);
        chk("reset.rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("reset.rsp_rdata", bus.rsp_rdata, 32'd0);
        chk("reset.rsp_error", 32'(bus.rsp_error), 32'd0);
        chk("reset.busy", 32'(bus.busy), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset.req_ready", 32'(bus.req_ready), 32'd1);

        for (int i = 0; i < 17; i++) begin
            send(vt[i].rw, vt[i].sz, vt[i].uns, vt[i].addr, vt[i].wd);
            finish_req($sformatf("vec%0d", i), vt[i].exp_rd, vt[i].exp_er, 0);
        end

        // Backpressure: response held for five cycles without rsp_ready.
        send(MEM_READ, SIZE_WORD, 1'b0, BASE + 8, 32'h0);
        finish_req("backpressure", 32'h12ADBEEF, 1'b0, 5);

        // Reset while waiting: the store must never land.
        send(MEM_WRITE, SIZE_WORD, 1'b0, BASE, 32'hCAFEF00D);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_wait.req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_wait.rsp_valid", 32'(bus.rsp_valid), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_wait.after_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_wait.after_rdata", bus.rsp_rdata, 32'd0);
        chk("rst_wait.after_error", 32'(bus.rsp_error), 32'd0);
        chk("rst_wait.after_busy", 32'(bus.busy), 32'd0);
        chk("rst_wait.after_req_ready", 32'(bus.req_ready), 32'd1);
        send(MEM_READ, SIZE_WORD, 1'b0, BASE, 32'h0);
        finish_req("rst_wait.readback", 32'h11223344, 1'b0, 0);

        // Reset landing on the ACCESS edge also drops the store.
        send(MEM_WRITE, SIZE_WORD, 1'b0, BASE, 32'hCAFEF00D);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_access.rsp_valid", 32'(bus.rsp_valid), 32'd0);
        send(MEM_READ, SIZE_WORD, 1'b0, BASE, 32'h0);
        finish_req("rst_access.readback", 32'h11223344, 1'b0, 0);

        // Random traffic over a 64-byte window plus out-of-range addresses.
        for (int w = 0; w < 16; w++) begin
            wd = $urandom;
            ref_access(MEM_WRITE, SIZE_WORD, 1'b0, BASE + 32'(4 * w), wd, rd, er);
            send(MEM_WRITE, SIZE_WORD, 1'b0, BASE + 32'(4 * w), wd);
            finish_req("rnd_init", rd, er, 0);
        end
        for (int k = 0; k < 150; k++) begin
            rw  = 1'($urandom_range(0, 1));
            sz  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            uns = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 15))
                0:       a = BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 7));
                1:       a = BASE - 32'($urandom_range(1, 8));
                default: a = BASE + 32'($urandom_range(0, 63));
            endcase
            wd = $urandom;
            ref_access(rw, sz, uns, a, wd, rd, er);
            send(rw, sz, uns, a, wd);
            finish_req($sformatf("rnd%0d", k), rd, er, int'($urandom_range(0, 9) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
